exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- int_in  in  6  external hardware interrupt lines, level-sensitive.
- mem_valid  in  1  MEM-stage instruction valid.
- mem_syscall  in  1  MEM-stage instruction is SYSCALL.
- mem_eret  in  1  MEM-stage instruction is ERET.
- mem_in_ds  in  1  MEM-stage instruction sits in a branch delay slot.
- mem_pc  in  32  MEM-stage instruction PC.
- cp0_status  in  32  current CP0 Status.
- cp0_ebase  in  32  current CP0 exception base.
- cp0_epc  in  32  current CP0 EPC.
- cp0_we  out  1  CP0 write strobe.
- cp0_waddr  out  5  CP0 register number.
- cp0_wdata  out  32  CP0 write data.
- flush  out  1  one-cycle pipeline flush.
- stall  out  1  pipeline hold.
- new_pc  out  32  redirect target.
- new_pc_valid  out  1  one-cycle redirect strobe.

Function
REQ-002 The FSM states SHALL be IDLE, W_EPC, W_CAUSE, W_STATUS and REDIR.
REQ-003 An interrupt request SHALL be: status[0]=1, status[1]=0, and (int_s & status[15:10]) nonzero.
- int_s is int_in after the optional synchronizer.
REQ-004 In IDLE, the block SHALL evaluate requests with this priority: interrupt > (mem_valid & mem_syscall) > (mem_valid & mem_eret).
REQ-005 When an interrupt or syscall is accepted, the block SHALL go to W_EPC and latch these values:
- epc_val = mem_pc, or mem_pc-4 when mem_in_ds=1 (32-bit wrap).
- bd = mem_in_ds.
- exccode = 5'b00000 for an interrupt, 5'b01000 for a syscall.
- ip = int_s.
- status snapshot.
REQ-006 When an ERET is accepted, the block SHALL go to W_STATUS with the status snapshot latched and the eret flag set.
REQ-007 In W_EPC the block SHALL drive cp0_we=1, waddr=14, wdata=epc_val, then go to W_CAUSE.
REQ-008 In W_CAUSE the block SHALL drive cp0_we=1 and waddr=13, then go to W_STATUS.
- wdata = {bd, 15'b0, ip, 3'b0, exccode, 2'b0}.
REQ-009 In W_STATUS the block SHALL drive cp0_we=1 and waddr=12, then go to REDIR.
- wdata = snapshot | 32'h2 for an exception.
- wdata = snapshot & ~32'h2 for an ERET.
REQ-010 In REDIR the block SHALL drive new_pc_valid=1 and return to IDLE.
- new_pc = cp0_ebase for an exception.
- new_pc = cp0_epc for an ERET.
REQ-011 Latency SHALL be fixed: a syscall sampled at edge N gives W_EPC at N+1 and new_pc_valid at N+4; an ERET gives new_pc_valid at N+2.
REQ-012 flush SHALL be 1 for exactly the first cycle after acceptance (W_EPC, or W_STATUS for ERET).
REQ-013 stall SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-014 While the FSM is non-IDLE, all new requests SHALL be ignored and not queued.
- An int_in level still asserted on return to IDLE is re-evaluated using the then-current cp0_status.
REQ-015 In IDLE, cp0_we, flush and new_pc_valid SHALL be 0, and cp0_waddr, cp0_wdata and new_pc SHALL be 0.
REQ-016 If mem_syscall and mem_eret are both 1, the syscall SHALL win.
REQ-017 Requests with mem_valid=0 SHALL be ignored; interrupts do not depend on mem_valid.

Reset
REQ-018 When rst=0, the block SHALL asynchronously force these values:
- FSM to IDLE.
- All latched fields to 0.
- Synchronizer flops to 0.
- All outputs to 0.
REQ-019 Reset asserted mid-sequence SHALL abandon it with no further CP0 writes.
- The first possible acceptance is the first rising edge after rst returns to 1.

Configuration
REQ-020 The macro EXC_CTRL_INT_SYNC_EN SHALL control the interrupt synchronizer:
- Defined: int_s comes through a 2-flop synchronizer on int_in, adding 2 cycles of interrupt latency.
- Undefined: int_s = int_in directly.
- Syscall and ERET timing are identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Syscall, mem_pc=0x00400020, in_ds=0, status=0x1001, ebase=0x80000180 -> writes (14,0x00400020), (13,0x00000020), (12,0x00001003); new_pc=0x80000180 at N+4; flush only at N+1.
- Syscall in delay slot, mem_pc=0x00400024 -> EPC write data 0x00400020; cause data 0x80000020.
- ERET, status=0x1003, epc=0x00400028 -> single write (12,0x00001001); new_pc=0x00400028 at N+2.
- int_in=6'b000100, status=0x1001 -> interrupt taken: cause data 0x00001000, exccode 0. Repeat with status=0x1003 -> no action. With EXC_CTRL_INT_SYNC_EN defined, detection is 2 cycles later.
- Interrupt and syscall in the same cycle -> interrupt sequence only. A second syscall during W_CAUSE -> ignored.
- rst=0 during W_CAUSE -> all outputs 0 immediately; no W_STATUS write; a syscall after release completes normally.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: writes EPC, Cause and Status to CP0 one per cycle, then redirects fetch.
// Build option: define EXC_CTRL_INT_SYNC_EN to pass int_in through a 2-flop synchronizer.
module exc_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  int_in,
   input  logic        mem_valid,
   input  logic        mem_syscall,
   input  logic        mem_eret,
   input  logic        mem_in_ds,
   input  logic [31:0] mem_pc,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_ebase,
   input  logic [31:0] cp0_epc,
   output logic        cp0_we,
   output logic [4:0]  cp0_waddr,
   output logic [31:0] cp0_wdata,
   output logic        flush,
   output logic        stall,
   output logic [31:0] new_pc,
   output logic        new_pc_valid
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_EPC    = 3'd1,
      W_CAUSE  = 3'd2,
      W_STATUS = 3'd3,
      REDIR    = 3'd4
   } state_t;

   typedef struct packed {
      logic        eret;
      logic        bd;
      logic [5:0]  ip;
      logic [4:0]  exccode;
      logic [31:0] status;
   } ctx_t;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;
   localparam logic [4:0] EXC_INT    = 5'b00000;
   localparam logic [4:0] EXC_SYS    = 5'b01000;
   localparam logic [31:0] EXL       = 32'h0000_0002;

   state_t     state;
   ctx_t       ctx;
   logic [5:0] int_s;
   logic       int_req, sys_req, eret_req;
   logic [31:0] epc_next;

`ifdef EXC_CTRL_INT_SYNC_EN
   logic [5:0] int_m, int_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_m <= '0;
         int_q <= '0;
      end else begin
         int_m <= int_in;
         int_q <= int_m;
      end
   end

   assign int_s = int_q;
`else
   assign int_s = int_in;
`endif

   // Interrupts need IE=1, EXL=0 and at least one line unmasked; they ignore mem_valid.
   assign int_req  = cp0_status[0] & ~cp0_status[1] & (|(int_s & cp0_status[15:10]));
   assign sys_req  = mem_valid & mem_syscall;
   assign eret_req = mem_valid & mem_eret;
   assign epc_next = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;

   // Outputs are registered alongside the state, so each edge loads the strobes of the
   // state being entered; the EPC value is carried straight into cp0_wdata on acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         ctx          <= '0;
         cp0_we       <= 1'b0;
         cp0_waddr    <= '0;
         cp0_wdata    <= '0;
         flush        <= 1'b0;
         stall        <= 1'b0;
         new_pc       <= '0;
         new_pc_valid <= 1'b0;
      end else begin
         cp0_we       <= 1'b0;
         cp0_waddr    <= '0;
         cp0_wdata    <= '0;
         flush        <= 1'b0;
         new_pc       <= '0;
         new_pc_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (int_req || sys_req) begin
                  state       <= W_EPC;
                  ctx.eret    <= 1'b0;
                  ctx.bd      <= mem_in_ds;
                  ctx.ip      <= int_s;
                  ctx.exccode <= int_req ? EXC_INT : EXC_SYS;
                  ctx.status  <= cp0_status;
                  cp0_we      <= 1'b1;
                  cp0_waddr   <= CP0_EPC;
                  cp0_wdata   <= epc_next;
                  flush       <= 1'b1;
                  stall       <= 1'b1;
               end else if (eret_req) begin
                  state       <= W_STATUS;
                  ctx.eret    <= 1'b1;
                  ctx.bd      <= 1'b0;
                  ctx.ip      <= '0;
                  ctx.exccode <= '0;
                  ctx.status  <= cp0_status;
                  cp0_we      <= 1'b1;
                  cp0_waddr   <= CP0_STATUS;
                  cp0_wdata   <= cp0_status & ~EXL;
                  flush       <= 1'b1;
                  stall       <= 1'b1;
               end else begin
                  stall <= 1'b0;
               end
            end
            W_EPC: begin
               state     <= W_CAUSE;
               cp0_we    <= 1'b1;
               cp0_waddr <= CP0_CAUSE;
               cp0_wdata <= {ctx.bd, 15'b0, ctx.ip, 3'b0, ctx.exccode, 2'b0};
               stall     <= 1'b1;
            end
            W_CAUSE: begin
               state     <= W_STATUS;
               cp0_we    <= 1'b1;
               cp0_waddr <= CP0_STATUS;
               cp0_wdata <= ctx.eret ? (ctx.status & ~EXL) : (ctx.status | EXL);
               stall     <= 1'b1;
            end
            W_STATUS: begin
               state        <= REDIR;
               new_pc_valid <= 1'b1;
               new_pc       <= ctx.eret ? cp0_epc : cp0_ebase;
               stall        <= 1'b1;
            end
            REDIR: begin
               state <= IDLE;
               stall <= 1'b0;
            end
            default: begin
               state <= IDLE;
               stall <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle expected output records queued with each stimulus.
module tb_exc_ctrl;

   logic        clk, rst;
   logic [5:0]  int_in;
   logic        mem_valid, mem_syscall, mem_eret, mem_in_ds;
   logic [31:0] mem_pc, cp0_status, cp0_ebase, cp0_epc;
   logic        cp0_we, flush, stall, new_pc_valid;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata, new_pc;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        flush;
      logic        stall;
      logic        npv;
      logic [31:0] npc;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  o;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   exc_ctrl dut (
      .clk(clk), .rst(rst), .int_in(int_in),
      .mem_valid(mem_valid), .mem_syscall(mem_syscall), .mem_eret(mem_eret),
      .mem_in_ds(mem_in_ds), .mem_pc(mem_pc),
      .cp0_status(cp0_status), .cp0_ebase(cp0_ebase), .cp0_epc(cp0_epc),
      .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
      .flush(flush), .stall(stall), .new_pc(new_pc), .new_pc_valid(new_pc_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input obs_t e);
      obs_t g;
      g = {cp0_we, cp0_waddr, cp0_wdata, flush, stall, new_pc_valid, new_pc};
      checks++;
      assert (g === e) passed++;
      else $error("FAIL %s: got we=%0d a=%0d d=%h fl=%0d st=%0d v=%0d pc=%h expected we=%0d a=%0d d=%h fl=%0d st=%0d v=%0d pc=%h",
                  tag, g.we, g.waddr, g.wdata, g.flush, g.stall, g.npv, g.npc,
                  e.we, e.waddr, e.wdata, e.flush, e.stall, e.npv, e.npc);
   endtask

   task automatic push_rec(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic fl, input logic st,
                           input logic v, input logic [31:0] pc);
      rec_t r;
      r.tag = tag;
      r.o   = {we, a, d, fl, st, v, pc};
      exp_q.push_back(r);
   endtask

   task automatic push_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) push_rec(tag, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0);
   endtask

   // Full exception: EPC, Cause, Status writes, redirect, then back in IDLE.
   task automatic push_exc(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] st, input logic [31:0] npc);
      push_rec({tag, "_epc"},    1, 5'd14, epc,   1, 1, 0, 32'h0);
      push_rec({tag, "_cause"},  1, 5'd13, cause, 0, 1, 0, 32'h0);
      push_rec({tag, "_status"}, 1, 5'd12, st,    0, 1, 0, 32'h0);
      push_rec({tag, "_redir"},  0, 5'd0,  32'h0, 0, 1, 1, npc);
      push_idle({tag, "_idle"}, 1);
   endtask

   task automatic push_eret(input string tag, input logic [31:0] st, input logic [31:0] npc);
      push_rec({tag, "_status"}, 1, 5'd12, st,    1, 1, 0, 32'h0);
      push_rec({tag, "_redir"},  0, 5'd0,  32'h0, 0, 1, 1, npc);
      push_idle({tag, "_idle"}, 1);
   endtask

   task automatic step();
      rec_t r;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         $error("FAIL scoreboard_empty: got no expected record, required one per cycle");
      end else begin
         r = exp_q.pop_front();
         chk(r.tag, r.o);
      end
   endtask

   task automatic drain();
      while (exp_q.size() > 0) step();
   endtask

   task automatic clear_req();
      mem_valid   = 0;
      mem_syscall = 0;
      mem_eret    = 0;
   endtask

   initial begin
      rst = 0; int_in = '0; clear_req(); mem_in_ds = 0; mem_pc = '0;
      cp0_status = 32'h1001; cp0_ebase = 32'h8000_0180; cp0_epc = '0;
      #1;
      chk("reset_state", '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      push_idle("post_reset", 2); drain();

      // Plain syscall
      mem_pc = 32'h0040_0020; mem_in_ds = 0; mem_valid = 1; mem_syscall = 1;
      push_exc("sys", 32'h0040_0020, 32'h0000_0020, 32'h0000_1003, 32'h8000_0180);
      step(); clear_req(); drain();

      // Syscall in a delay slot
      mem_pc = 32'h0040_0024; mem_in_ds = 1; mem_valid = 1; mem_syscall = 1;
      push_exc("sys_ds", 32'h0040_0020, 32'h8000_0020, 32'h0000_1003, 32'h8000_0180);
      step(); clear_req(); mem_in_ds = 0; drain();

      // ERET
      cp0_status = 32'h1003; cp0_epc = 32'h0040_0028; mem_valid = 1; mem_eret = 1;
      push_eret("eret", 32'h0000_1001, 32'h0040_0028);
      step(); clear_req(); drain();

      // Invalid instruction slot is ignored
      cp0_status = 32'h1001; mem_valid = 0; mem_syscall = 1; mem_eret = 1;
      push_idle("no_valid", 3); drain(); clear_req();

      // Syscall beats ERET
      mem_pc = 32'h0040_0060; mem_valid = 1; mem_syscall = 1; mem_eret = 1;
      push_exc("sys_eret", 32'h0040_0060, 32'h0000_0020, 32'h0000_1003, 32'h8000_0180);
      step(); clear_req(); drain();

      // Interrupt on line 2
      mem_pc = 32'h0040_0030; int_in = 6'b000100;
`ifdef EXC_CTRL_INT_SYNC_EN
      push_idle("int_sync", 2); drain();
`endif
      push_exc("int", 32'h0040_0030, 32'h0000_1000, 32'h0000_1003, 32'h8000_0180);
      step(); int_in = '0; drain();
      push_idle("int_flush", 3); drain();

      // Interrupt masked by EXL
      cp0_status = 32'h1003; int_in = 6'b000100;
      push_idle("int_exl", 4); drain();
      int_in = '0;
      push_idle("int_exl_flush", 3); drain();
      cp0_status = 32'h1001;

      // Interrupt and syscall together; a second syscall in W_CAUSE is dropped
`ifdef EXC_CTRL_INT_SYNC_EN
      int_in = 6'b000100;
      push_idle("both_sync", 2); drain();
`endif
      int_in = 6'b000100; mem_pc = 32'h0040_0040; mem_valid = 1; mem_syscall = 1;
      push_exc("both", 32'h0040_0040, 32'h0000_1000, 32'h0000_1003, 32'h8000_0180);
      step(); clear_req(); int_in = '0;
      step(); mem_valid = 1; mem_syscall = 1;
      step(); clear_req();
      drain();
      push_idle("late_sys_dropped", 3); drain();

      // Reset during W_CAUSE
      mem_pc = 32'h0040_0050; mem_valid = 1; mem_syscall = 1;
      push_rec("rst_epc",   1, 5'd14, 32'h0040_0050, 1, 1, 0, 32'h0);
      push_rec("rst_cause", 1, 5'd13, 32'h0000_0020, 0, 1, 0, 32'h0);
      step(); clear_req();
      step();
      rst = 0;
      #1;
      chk("rst_async", '0);
      @(posedge clk);
      #1;
      chk("rst_held", '0);
      rst = 1; mem_valid = 1; mem_syscall = 1;
      push_exc("after_rst", 32'h0040_0050, 32'h0000_0020, 32'h0000_1003, 32'h8000_0180);
      step(); clear_req(); drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
